// File: rtl/gpi_debounce_irq_if.sv
// Slot-bus bundle shared by the I/O cores: 5-bit register index, 32-bit data paths.
interface gpi_debounce_irq_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (output cs, read, write, addr, write_data, input read_data);
  modport slave  (input cs, read, write, addr, write_data, output read_data);
endinterface

// File: rtl/gpi_debounce_irq.sv
// General-purpose input port with 2-FF sync, prescaled per-bit debounce,
// selectable rising/falling edge capture and a maskable level interrupt.
module gpi_debounce_irq #(
  parameter int unsigned W          = 8,
  parameter int unsigned DB_SAMPLES = 4,
  parameter logic [15:0] DB_DEFAULT = 16'd0
) (
  input  logic                clk,
  input  logic                rst,
  gpi_debounce_irq_if.slave   bus,
  input  logic [W-1:0]        data_in,
  output logic                irq
);

  localparam logic [3:0] CNT_LAST = 4'(DB_SAMPLES - 1);

  logic [W-1:0] s1, s2, deb, deb_d;
  logic [W-1:0] edge_st, irq_en, edge_sel;
  logic [15:0]  db_period, presc;
  logic [3:0]   cnt [W];

  logic         wr, wr_period, tick;
  logic [W-1:0] w1c_mask, rise, fall, ev;
  logic         unused_inputs;

  assign wr        = bus.cs && bus.write;
  assign wr_period = wr && (bus.addr == 5'd4);
  assign tick      = (presc == db_period);
  assign w1c_mask  = (wr && bus.addr == 5'd1) ? bus.write_data[W-1:0] : '0;
  assign rise      = deb & ~deb_d;
  assign fall      = ~deb & deb_d;
  assign ev        = (edge_sel & fall) | (~edge_sel & rise);

  // Reads have no side effects, so the strobe and upper data bits go nowhere.
  assign unused_inputs = bus.read ^ (^bus.write_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      deb       <= '0;
      deb_d     <= '0;
      edge_st   <= '0;
      irq_en    <= '0;
      edge_sel  <= '0;
      db_period <= DB_DEFAULT;
      presc     <= '0;
      for (int unsigned i = 0; i < W; i++) cnt[i] <= '0;
    end else begin
      s1      <= data_in;
      s2      <= s1;
      deb_d   <= deb;
      // A new event in the same cycle as its W1C clear keeps the bit set.
      edge_st <= (edge_st & ~w1c_mask) | ev;

      if (wr && bus.addr == 5'd2) irq_en   <= bus.write_data[W-1:0];
      if (wr && bus.addr == 5'd3) edge_sel <= bus.write_data[W-1:0];

      if (wr_period) begin
        // Restart qualification from scratch; the debounced value is kept.
        db_period <= bus.write_data[15:0];
        presc     <= '0;
        for (int unsigned i = 0; i < W; i++) cnt[i] <= '0;
      end else if (db_period == '0) begin
        deb   <= s2;
        presc <= '0;
        for (int unsigned i = 0; i < W; i++) cnt[i] <= '0;
      end else begin
        presc <= tick ? '0 : presc + 16'd1;
        for (int unsigned i = 0; i < W; i++) begin
          if (s2[i] == deb[i]) begin
            cnt[i] <= '0;
          end else if (tick) begin
            if (cnt[i] == CNT_LAST) begin
              deb[i] <= s2[i];
              cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + 4'd1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    bus.read_data = '0;
    case (bus.addr)
      5'd0: bus.read_data[W-1:0] = deb;
      5'd1: bus.read_data[W-1:0] = edge_st;
      5'd2: bus.read_data[W-1:0] = irq_en;
      5'd3: bus.read_data[W-1:0] = edge_sel;
      5'd4: bus.read_data[15:0]  = db_period;
      5'd5: bus.read_data[W-1:0] = s2;
      default: bus.read_data = '0;
    endcase
  end

  assign irq = |(edge_st & irq_en);

endmodule

// File: tb/tb_gpi_debounce_irq.sv
// Directed bench for gpi_debounce_irq: reset, bypass latency, debounce, edge modes, W1C race, reset mid-qualify.
module tb_gpi_debounce_irq;
  localparam logic [15:0] DEF_PERIOD = 16'd9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = '0;
  logic       irq;
  int         total = 0;
  int         bad   = 0;

  gpi_debounce_irq_if bus ();

  gpi_debounce_irq #(.W(8), .DB_SAMPLES(4), .DB_DEFAULT(DEF_PERIOD)) dut (
    .clk(clk), .rst(rst), .bus(bus), .data_in(data_in), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.read_data;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.write_data = d;
    step(1);
    bus.cs = 1'b0; bus.write = 1'b0; bus.write_data = '0;
  endtask

  initial begin
    logic [31:0] d;
    int          n;
    bit          found;

    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.write_data = '0;

    // 1: reset state
    step(2);
    rst = 1'b0;
    chk_reg("rst_data", 5'd0, 32'h0);
    chk_reg("rst_edge", 5'd1, 32'h0);
    chk_reg("rst_irqen", 5'd2, 32'h0);
    chk_reg("rst_edgesel", 5'd3, 32'h0);
    chk_reg("rst_period", 5'd4, {16'h0, DEF_PERIOD});
    chk_reg("rst_raw", 5'd5, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    for (int a = 6; a < 32; a++) chk_reg($sformatf("unmapped_%0d", a), 5'(a), 32'h0);

    // 2: bypass latency and W1C
    wr(5'd4, 32'h0);
    wr(5'd2, 32'h1);
    wr(5'd0, 32'hFF);
    chk_reg("ro_write_ignored", 5'd0, 32'h0);
    data_in = 8'h05;
    step(2);
    chk_reg("byp_raw_e2", 5'd5, 32'h05);
    chk_reg("byp_data_e2", 5'd0, 32'h00);
    step(1);
    chk_reg("byp_data_e3", 5'd0, 32'h05);
    chk_reg("byp_edge_e3", 5'd1, 32'h00);
    step(1);
    chk_reg("byp_edge_e4", 5'd1, 32'h05);
    check("byp_irq_e4", {31'h0, irq}, 32'h1);
    wr(5'd1, 32'h01);
    chk_reg("byp_w1c", 5'd1, 32'h04);
    check("byp_irq_cleared", {31'h0, irq}, 32'h0);
    data_in = 8'h00;
    step(5);
    wr(5'd1, 32'hFF);
    chk_reg("byp_edge_clear", 5'd1, 32'h00);

    // 3: debounce with period 9 (tick every 10 cycles, 4 ticks to accept)
    wr(5'd4, 32'd9);
    chk_reg("db_period_rb", 5'd4, 32'd9);
    data_in = 8'h01;
    step(25);
    data_in = 8'h00;
    step(20);
    chk_reg("db_glitch_data", 5'd0, 32'h00);
    chk_reg("db_glitch_edge", 5'd1, 32'h00);
    data_in = 8'h01;
    found = 1'b0;
    n = 0;
    for (int k = 1; k <= 60 && !found; k++) begin
      step(1);
      rd(5'd0, d);
      if (d[0]) begin
        found = 1'b1;
        n = k;
      end
    end
    check("db_accept_found", {31'h0, found}, 32'h1);
    check("db_accept_window", {31'h0, (n >= 33 && n <= 43)}, 32'h1);
    step(1);
    chk_reg("db_edge", 5'd1, 32'h01);
    check("db_irq", {31'h0, irq}, 32'h1);

    // 4: falling mode on bit1
    wr(5'd4, 32'h0);
    data_in = 8'h02;
    step(5);
    wr(5'd1, 32'hFF);
    wr(5'd3, 32'h02);
    chk_reg("fall_sel_rb", 5'd3, 32'h02);
    chk_reg("fall_pre_edge", 5'd1, 32'h00);
    data_in = 8'h00;
    step(5);
    chk_reg("fall_capture", 5'd1, 32'h02);
    wr(5'd1, 32'hFF);
    data_in = 8'h02;
    step(5);
    chk_reg("fall_rise_ignored", 5'd1, 32'h00);

    // 5: W1C of bit2 on the very edge its rising event is captured
    wr(5'd3, 32'h00);
    data_in = 8'h06;
    step(3);
    wr(5'd1, 32'h04);
    chk_reg("race_w1c_loses", 5'd1, 32'h04);
    wr(5'd1, 32'h04);
    chk_reg("race_later_clear", 5'd1, 32'h00);

    // 6: reset mid-debounce discards counter progress
    wr(5'd4, 32'd9);
    data_in = 8'h0E;
    step(30);
    chk_reg("mid_pre_rst_data", 5'd0, 32'h06);
    wr(5'd2, 32'hFF);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_reg("mid_rst_data", 5'd0, 32'h00);
    chk_reg("mid_rst_irqen", 5'd2, 32'h00);
    chk_reg("mid_rst_period", 5'd4, {16'h0, DEF_PERIOD});
    chk_reg("mid_rst_raw", 5'd5, 32'h00);
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    step(35);
    chk_reg("mid_requal_early", 5'd0, 32'h00);
    found = 1'b0;
    n = 0;
    for (int k = 36; k <= 50 && !found; k++) begin
      step(1);
      rd(5'd0, d);
      if (d[3]) begin
        found = 1'b1;
        n = k;
      end
    end
    check("mid_requal_found", {31'h0, found}, 32'h1);
    check("mid_requal_edge_no", n, 32'd40);
    chk_reg("mid_requal_data", 5'd0, 32'h0E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
